// File: rtl/top_spi.sv
// -----------------------------------------------------------------------------
// top_spi : SPI mode-0 slave, oversampled by the system clock.
//
// Receives bytes MSB first on SPI_MOSI (sampled on SCK rising edges) and shows
// the last complete byte on led. Each message (CS falling edge) bumps an 8-bit
// message counter whose new value is shifted out MSB first on SPI_MISO
// (advanced on SCK falling edges).
//
// Ports
//   clk                 in   system clock, all state on its rising edge
//   rst_n               in   asynchronous reset, active HIGH despite the name
//   SPI_SCK             in   SPI clock from master (async, idle low)
//   SPI_CS              in   SPI chip select, active low (async)
//   SPI_MOSI            in   master-out data (async)
//   SPI_MISO            out  slave-out data, 0 while not selected
//   led                 out  last complete byte received
//   bitcnt              out  bits received in the current byte, 0..7
//   byte_data_received  out  live receive shift register
// -----------------------------------------------------------------------------
module top_spi (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       SPI_SCK,
   input  logic       SPI_CS,
   input  logic       SPI_MOSI,
   output logic       SPI_MISO,
   output logic [7:0] led,
   output logic [3:0] bitcnt,
   output logic [7:0] byte_data_received
);

   // Synchronizers: bit 0 is the newest sample, bit 2 (or 1) the oldest.
   logic [2:0] sck_q;
   logic [2:0] cs_q;
   logic [1:0] mosi_q;

   logic       armed_q,  armed_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic [7:0] rx_q,     rx_d;
   logic [7:0] led_q,    led_d;
   logic       strobe_q, strobe_d;
   logic [7:0] msg_q,    msg_d;
   logic [7:0] tx_q,     tx_d;

   logic sck_rise;
   logic sck_fall;
   logic cs_fall;
   logic cs_active;

   assign sck_rise = (sck_q[2:1] == 2'b01);
   assign sck_fall = (sck_q[2:1] == 2'b10);
   assign cs_fall  = (cs_q[2:1]  == 2'b10);

   // The synchronizers reset to 0, which would read as "CS low". armed_q keeps
   // the slave deaf until a real CS falling edge has been seen after reset.
   assign cs_active = ~cs_q[2] & armed_q;

   always_comb begin
      armed_d  = armed_q;
      bitcnt_d = bitcnt_q;
      rx_d     = rx_q;
      msg_d    = msg_q;
      tx_d     = tx_q;
      strobe_d = 1'b0;
      led_d    = strobe_q ? rx_q : led_q;

      // CS events take precedence over any coincident SCK edge.
      if (cs_fall) begin
         armed_d  = 1'b1;
         bitcnt_d = 3'd0;
         msg_d    = msg_q + 8'd1;
         tx_d     = msg_q + 8'd1;
      end else if (!cs_active) begin
         // Deselected: drop any partial byte count, hold data registers.
         bitcnt_d = 3'd0;
         if (cs_q[2]) begin
            armed_d = 1'b0;
         end
      end else if (sck_rise) begin
         rx_d     = {rx_q[6:0], mosi_q[1]};
         bitcnt_d = bitcnt_q + 3'd1;
         strobe_d = (bitcnt_q == 3'd7);
      end else if (sck_fall) begin
         tx_d = {tx_q[6:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         sck_q    <= '0;
         cs_q     <= '0;
         mosi_q   <= '0;
         armed_q  <= 1'b0;
         bitcnt_q <= '0;
         rx_q     <= '0;
         led_q    <= '0;
         strobe_q <= 1'b0;
         msg_q    <= '0;
         tx_q     <= '0;
      end else begin
         sck_q    <= {sck_q[1:0], SPI_SCK};
         cs_q     <= {cs_q[1:0], SPI_CS};
         mosi_q   <= {mosi_q[0], SPI_MOSI};
         armed_q  <= armed_d;
         bitcnt_q <= bitcnt_d;
         rx_q     <= rx_d;
         led_q    <= led_d;
         strobe_q <= strobe_d;
         msg_q    <= msg_d;
         tx_q     <= tx_d;
      end
   end

   assign SPI_MISO           = cs_active & tx_q[7];
   assign led                = led_q;
   assign bitcnt             = {1'b0, bitcnt_q};
   assign byte_data_received = rx_q;

endmodule

// File: tb/tb_top_spi.sv
module tb_top_spi;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       SPI_SCK = 1'b0;
   logic       SPI_CS = 1'b1;
   logic       SPI_MOSI = 1'b0;
   logic       SPI_MISO;
   logic [7:0] led;
   logic [3:0] bitcnt;
   logic [7:0] byte_data_received;

   top_spi dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .SPI_SCK            (SPI_SCK),
      .SPI_CS             (SPI_CS),
      .SPI_MOSI           (SPI_MOSI),
      .SPI_MISO           (SPI_MISO),
      .led                (led),
      .bitcnt             (bitcnt),
      .byte_data_received (byte_data_received)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;

   // Reference model state: message count, bytes in current message, last byte.
   logic [7:0] exp_led_q[$];
   int         m_msg = 0;
   int         m_idx = 0;
   logic [7:0] m_led = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_led"}, {24'd0, led}, 32'd0);
      chk({tag, "_bitcnt"}, {28'd0, bitcnt}, 32'd0);
      chk({tag, "_rxreg"}, {24'd0, byte_data_received}, 32'd0);
      chk({tag, "_miso"}, {31'd0, SPI_MISO}, 32'd0);
   endtask

   task automatic cs_low();
      SPI_CS = 1'b0;
      m_msg  = (m_msg + 1) % 256;
      m_idx  = 0;
      #200;
   endtask

   task automatic cs_high();
      #200;
      SPI_CS = 1'b1;
      #200;
   endtask

   // Master side of one byte (or a partial byte when nbits < 8).
   task automatic send_byte(input logic [7:0] d, input int nbits);
      logic [7:0] miso_b;
      logic [7:0] exp_tx;
      miso_b = 8'h00;
      exp_tx = (m_idx == 0) ? m_msg[7:0] : 8'h00;
      if (nbits == 8) begin
         exp_led_q.push_back(d);
         m_led = d;
      end
      for (int i = 0; i < nbits; i++) begin
         SPI_MOSI = d[7-i];
         #200;
         SPI_SCK = 1'b1;
         miso_b = {miso_b[6:0], SPI_MISO};
         #100;
         chk("bitcnt_step", {28'd0, bitcnt}, (i + 1) % 8);
         #100;
         SPI_SCK = 1'b0;
      end
      if (nbits == 8) begin
         m_idx++;
         #100;
         chk("rx_byte", {24'd0, byte_data_received}, {24'd0, d});
         chk("miso_byte", {24'd0, miso_b}, {24'd0, exp_tx});
      end
   endtask

   // Monitor: every receive strobe must match the next expected byte on led.
   initial begin
      forever begin
         @(negedge clk);
         if (dut.strobe_q === 1'b1) begin
            @(negedge clk);
            if (exp_led_q.size() == 0) begin
               chk("led_unexpected_strobe", {24'd0, led}, 32'hFFFF_FFFF);
            end else begin
               chk("led_scoreboard", {24'd0, led}, {24'd0, exp_led_q.pop_front()});
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset phase and idle after release.
      #50;
      chk_zero("reset");
      #50;
      rst_n = 1'b0;
      #200;
      chk_zero("idle");

      // Directed bytes: first message gives MISO 0x01, second 0x02.
      cs_low();
      send_byte(8'hFF, 8);
      cs_high();
      chk("led_ff", {24'd0, led}, 32'hFF);
      cs_low();
      send_byte(8'hA5, 8);
      cs_high();
      chk("led_a5", {24'd0, led}, 32'hA5);

      // Abort after 5 bits, then a full byte.
      cs_low();
      send_byte(8'h3C, 5);
      cs_high();
      chk("abort_bitcnt", {28'd0, bitcnt}, 32'd0);
      chk("abort_led", {24'd0, led}, {24'd0, m_led});
      cs_low();
      send_byte(8'h5A, 8);
      cs_high();

      // Randomized messages, some ending in an aborted partial byte.
      repeat (8) begin
         int nb;
         cs_low();
         nb = $urandom_range(1, 3);
         repeat (nb) send_byte(8'($urandom), 8);
         if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), $urandom_range(1, 7));
         cs_high();
         chk("msg_led", {24'd0, led}, {24'd0, m_led});
         chk("msg_bitcnt", {28'd0, bitcnt}, 32'd0);
      end

      // Reset mid-byte with CS held low.
      cs_low();
      send_byte(8'hC3, 3);
      #3;
      rst_n = 1'b1;
      #20;
      chk_zero("midreset");
      m_msg = 0;
      m_led = 8'h00;
      #100;
      rst_n = 1'b0;
      // SCK activity without a fresh CS edge must be ignored.
      repeat (2) begin
         SPI_MOSI = 1'b1;
         #200;
         SPI_SCK = 1'b1;
         #200;
         SPI_SCK = 1'b0;
      end
      #100;
      chk_zero("postreset");
      cs_high();
      cs_low();
      send_byte(8'h96, 8);
      cs_high();
      chk("led_after_reset", {24'd0, led}, 32'h96);

      #500;
      chk("scoreboard_drained", exp_led_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
